mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: one-at-a-time load/store front end for a RAM with registered read data.
// Define MEM_CTRL_WRITE_VERIFY_EN to read back each store and flag a mismatch on rsp_error.
module mem_ctrl #(
   parameter int data_width = 16,
   parameter int addr_width = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [addr_width-1:0] req_addr,
   input  logic [data_width-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [data_width-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [addr_width-1:0] ram_read_address,
   output logic [addr_width-1:0] ram_write_address,
   output logic                  ram_write,
   output logic [data_width-1:0] ram_din,
   input  logic [data_width-1:0] ram_dout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_CAP  = 3'd2,
      WR      = 3'd3
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      ,
      VF_WAIT = 3'd4,
      VF_CAP  = 3'd5
`endif
   } state_t;

   state_t                r_state;
   logic                  r_rsp_valid;
   logic [data_width-1:0] r_rsp_rdata;
   logic [addr_width-1:0] r_ram_read_address;
   logic [addr_width-1:0] r_ram_write_address;
   logic                  r_ram_write;
   logic [data_width-1:0] r_ram_din;
   logic                  w_accept;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
   logic                  r_rsp_error;
`endif

   // Ready is combinational so the first edge after reset release can accept.
   assign req_ready         = (r_state == IDLE) && !reset;
   assign w_accept          = req_valid && req_ready;
   assign rsp_valid         = r_rsp_valid;
   assign rsp_rdata         = r_rsp_rdata;
   assign ram_read_address  = r_ram_read_address;
   assign ram_write_address = r_ram_write_address;
   assign ram_write         = r_ram_write;
   assign ram_din           = r_ram_din;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
   assign rsp_error         = r_rsp_error;
`else
   assign rsp_error         = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state             <= IDLE;
         r_rsp_valid         <= 1'b0;
         r_rsp_rdata         <= '0;
         r_ram_read_address  <= '0;
         r_ram_write_address <= '0;
         r_ram_write         <= 1'b0;
         r_ram_din           <= '0;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
         r_rsp_error         <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ram_read_address <= req_addr;
                  if (req_write) begin
                     r_ram_write_address <= req_addr;
                     r_ram_din           <= req_wdata;
                     r_ram_write         <= 1'b1;
                     r_state             <= WR;
                  end else begin
                     r_state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: r_state <= RD_CAP;
            RD_CAP: begin
               r_rsp_rdata <= ram_dout;
               r_rsp_valid <= 1'b1;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
               r_rsp_error <= 1'b0;
`endif
               r_state     <= IDLE;
            end
            WR: begin
               r_ram_write <= 1'b0;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
               r_state     <= VF_WAIT;
`else
               r_rsp_valid <= 1'b1;
               r_state     <= IDLE;
`endif
            end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            // Read address still points at the stored word; ram_din keeps the written value.
            VF_WAIT: r_state <= VF_CAP;
            VF_CAP: begin
               r_rsp_rdata <= ram_dout;
               r_rsp_error <= (ram_dout != r_ram_din);
               r_rsp_valid <= 1'b1;
               r_state     <= IDLE;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural RAM with optional stuck bit, reference memory array, random ops.
module tb_mem_ctrl;
   localparam int DW = 16;
   localparam int AW = 8;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int LD_LAT = 3;
   localparam int ST_LAT = VERIFY ? 4 : 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_error;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ram_read_address, ram_write_address;
   logic          ram_write;
   logic [DW-1:0] ram_din, ram_dout;

   logic [DW-1:0] ram_mem [256];
   logic          stuck_en;
   logic [DW-1:0] exp_mem [256];
   bit            known [256];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   mem_ctrl #(.data_width(DW), .addr_width(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
      .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Registered-read RAM, read-before-write; stuck_en forces bit 0 low on reads.
   always @(posedge clk) begin
      ram_dout <= stuck_en ? (ram_mem[ram_read_address] & 16'hFFFE) : ram_mem[ram_read_address];
      if (ram_write) ram_mem[ram_write_address] <= ram_din;
   end

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return stuck_en ? (exp_mem[a] & 16'hFFFE) : exp_mem[a];
   endfunction

   // Issues one operation and observes it until its response (or a 20-cycle bound).
   task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic acc, output int lat, output int wp,
                        output logic [AW-1:0] wa, output logic [DW-1:0] wd,
                        output logic [AW-1:0] ra, output logic [DW-1:0] rd, output logic er);
      lat = 0; wp = 0; wa = '0; wd = '0; ra = '0; rd = '0; er = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      acc = req_ready;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 16'($urandom);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) ra = ram_read_address;
         if (ram_write) begin wp++; wa = ram_write_address; wd = ram_din; end
         if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_error; break; end
      end
      if (wr) begin exp_mem[a] = d; known[a] = 1'b1; end
   endtask

   task automatic test_reset();
      logic acc, er; int lat, wp; logic [AW-1:0] wa, ra; logic [DW-1:0] wd, rd;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      do_op(1'b1, 8'h5A, 16'h1234, acc, lat, wp, wa, wd, ra, rd, er);
      do_op(1'b0, 8'h5A, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL pre_reset_load: got %h expected 1234", rd); end
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL rst_rsp_error: got %b expected 0", rsp_error); end
      checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
      checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL rst_ram_write: got %b expected 0", ram_write); end
      checks++; if (ram_din !== 16'h0) begin errors++; $display("FAIL rst_ram_din: got %h expected 0", ram_din); end
      checks++; if (ram_read_address !== 8'h0) begin errors++; $display("FAIL rst_rd_addr: got %h expected 0", ram_read_address); end
      checks++; if (ram_write_address !== 8'h0) begin errors++; $display("FAIL rst_wr_addr: got %h expected 0", ram_write_address); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_held_ready: got %b expected 0", req_ready); end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b expected 1", req_ready); end
      do_op(1'b0, 8'h5A, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL first_accept: got %b expected 1", acc); end
      checks++; if (lat !== LD_LAT) begin errors++; $display("FAIL first_load_lat: got %0d expected %0d", lat, LD_LAT); end
      checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL first_load_data: got %h expected 1234", rd); end
   endtask

   task automatic test_store_load();
      logic acc, er; int lat, wp; logic [AW-1:0] wa, ra; logic [DW-1:0] wd, rd;
      do_op(1'b1, 8'h12, 16'hBEEF, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (wp !== 1) begin errors++; $display("FAIL st_wr_pulses: got %0d expected 1", wp); end
      checks++; if (wa !== 8'h12) begin errors++; $display("FAIL st_wr_addr: got %h expected 12", wa); end
      checks++; if (wd !== 16'hBEEF) begin errors++; $display("FAIL st_din: got %h expected beef", wd); end
      checks++; if (lat !== ST_LAT) begin errors++; $display("FAIL st_lat: got %0d expected %0d", lat, ST_LAT); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL st_err: got %b expected 0", er); end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL st_readback: got %h expected beef", rd); end
`endif
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL st_pulse_width: got %b expected 0", rsp_valid); end
      do_op(1'b0, 8'h12, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (lat !== LD_LAT) begin errors++; $display("FAIL ld_lat: got %0d expected %0d", lat, LD_LAT); end
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL ld_data: got %h expected beef", rd); end
      checks++; if (ra !== 8'h12) begin errors++; $display("FAIL ld_addr: got %h expected 12", ra); end
      checks++; if (wp !== 0) begin errors++; $display("FAIL ld_wr_pulses: got %0d expected 0", wp); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ld_pulse_width: got %b expected 0", rsp_valid); end
      checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL ld_hold: got %h expected beef", rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      int st_lat = 0, ld_lat = 0, wp = 0, busy_rdy = 0;
      logic rdy_at_rsp = 1'b0;
      logic [DW-1:0] rd = '0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'hFF; req_wdata = 16'h0001;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ram_write) wp++;
         if (rsp_valid) begin
            st_lat = k; rdy_at_rsp = req_ready;
            req_write = 1'b0; req_wdata = 16'hDEAD;
            break;
         end
         if (req_ready) busy_rdy++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ram_write) wp++;
         if (rsp_valid) begin ld_lat = k; rd = rsp_rdata; break; end
      end
      exp_mem[8'hFF] = 16'h0001; known[8'hFF] = 1'b1;
      checks++; if (st_lat !== ST_LAT) begin errors++; $display("FAIL b2b_st_lat: got %0d expected %0d", st_lat, ST_LAT); end
      checks++; if (busy_rdy !== 0) begin errors++; $display("FAIL b2b_busy_ready: got %0d cycles expected 0", busy_rdy); end
      checks++; if (rdy_at_rsp !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_rsp: got %b expected 1", rdy_at_rsp); end
      checks++; if (ld_lat !== LD_LAT) begin errors++; $display("FAIL b2b_ld_lat: got %0d expected %0d", ld_lat, LD_LAT); end
      checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL b2b_ld_data: got %h expected 0001", rd); end
      checks++; if (wp !== 1) begin errors++; $display("FAIL b2b_wr_pulses: got %0d expected 1", wp); end
   endtask

   task automatic test_reset_mid_op();
      logic acc, er; int lat, wp, pulses; logic [AW-1:0] wa, ra; logic [DW-1:0] wd, rd;
      do_op(1'b1, 8'h00, 16'hA5C3, acc, lat, wp, wa, wd, ra, rd, er);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rdcap_reset_rsp: got %0d pulses expected 0", pulses); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rdcap_reset_idle: got %b expected 1", req_ready); end
      do_op(1'b0, 8'h00, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (lat !== LD_LAT) begin errors++; $display("FAIL post_rst_ld_lat: got %0d expected %0d", lat, LD_LAT); end
      checks++; if (rd !== exp_mem[8'h00]) begin errors++; $display("FAIL post_rst_ld_data: got %h expected %h", rd, exp_mem[8'h00]); end

      do_op(1'b1, 8'h33, 16'h1111, acc, lat, wp, wa, wd, ra, rd, er);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 16'h2222;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL st_rst_wr: got %b expected 0", ram_write); end
      @(posedge clk);
      #2 reset = 1'b0;
      do_op(1'b0, 8'h33, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL st_rst_nocommit: got %h expected 1111", rd); end
   endtask

   task automatic test_stuck_bit();
      logic acc, er; int lat, wp; logic [AW-1:0] wa, ra; logic [DW-1:0] wd, rd;
      logic [DW-1:0] exp_rb;
      logic          exp_er;
      stuck_en = 1'b1;
      do_op(1'b1, 8'h40, 16'hBEEF, acc, lat, wp, wa, wd, ra, rd, er);
      exp_rb = model_read(8'h40);
      exp_er = VERIFY && (exp_rb != 16'hBEEF);
      checks++; if (er !== exp_er) begin errors++; $display("FAIL stuck_err: got %b expected %b", er, exp_er); end
      checks++; if (lat !== ST_LAT) begin errors++; $display("FAIL stuck_lat: got %0d expected %0d", lat, ST_LAT); end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      checks++; if (rd !== exp_rb) begin errors++; $display("FAIL stuck_readback: got %h expected %h", rd, exp_rb); end
`endif
      do_op(1'b0, 8'h40, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (rd !== 16'hBEEE) begin errors++; $display("FAIL stuck_load: got %h expected beee", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL stuck_load_err: got %b expected 0", er); end
      stuck_en = 1'b0;
      do_op(1'b0, 8'h40, 16'h0000, acc, lat, wp, wa, wd, ra, rd, er);
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL unstuck_load: got %h expected beef", rd); end
   endtask

   task automatic test_random();
      logic acc, er; int lat, wp; logic [AW-1:0] wa, ra; logic [DW-1:0] wd, rd;
      logic wr; logic [AW-1:0] a; logic [DW-1:0] d, exp_rd;
      for (int n = 0; n < 60; n++) begin
         a  = 8'($urandom);
         if (n % 10 == 0) a = 8'h00;
         if (n % 10 == 5) a = 8'hFF;
         wr = 1'($urandom);
         if (!known[a]) wr = 1'b1;
         d  = 16'($urandom);
         exp_rd = exp_mem[a];
         do_op(wr, a, d, acc, lat, wp, wa, wd, ra, rd, er);
         checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rnd_accept[%0d]: got %b expected 1", n, acc); end
         checks++; if (er !== 1'b0) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected 0", n, er); end
         checks++; if (ra !== a) begin errors++; $display("FAIL rnd_rd_addr[%0d]: got %h expected %h", n, ra, a); end
         if (wr) begin
            checks++; if (lat !== ST_LAT) begin errors++; $display("FAIL rnd_st_lat[%0d]: got %0d expected %0d", n, lat, ST_LAT); end
            checks++; if (wp !== 1) begin errors++; $display("FAIL rnd_st_pulses[%0d]: got %0d expected 1", n, wp); end
            checks++; if (wa !== a) begin errors++; $display("FAIL rnd_st_addr[%0d]: got %h expected %h", n, wa, a); end
            checks++; if (wd !== d) begin errors++; $display("FAIL rnd_st_din[%0d]: got %h expected %h", n, wd, d); end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
            checks++; if (rd !== d) begin errors++; $display("FAIL rnd_st_readback[%0d]: got %h expected %h", n, rd, d); end
`endif
         end else begin
            checks++; if (lat !== LD_LAT) begin errors++; $display("FAIL rnd_ld_lat[%0d]: got %0d expected %0d", n, lat, LD_LAT); end
            checks++; if (wp !== 0) begin errors++; $display("FAIL rnd_ld_pulses[%0d]: got %0d expected 0", n, wp); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_ld_data[%0d]: got %h expected %h", n, rd, exp_rd); end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      stuck_en = 1'b0;
      test_reset();
      test_store_load();
      test_back_to_back();
      test_reset_mid_op();
      test_stuck_bit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
